// File: rtl/addsub_issue_stage.sv
// Two-stage valid/ready wrapper around an external combinational adder.
// S1 holds the operands and forms add_*; S2 holds the result and flags. An architectural carry links ADDC/SUBB chains.
module addsub_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_c0,
    input  logic [WIDTH:0]   add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags,
    output logic             carry_flag
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBB = 2'b11;

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             carry_q, carry_d;

    logic             advance;
    logic             accept;
    logic             flag_n, flag_z, flag_c, flag_v;

    // Operand forming uses only registered S1 state plus the live carry, so
    // a chained op sees the carry written by its predecessor's advance.
    always_comb begin
        add_a = a_q;
        add_b = op_q[1] ? ~b_q : b_q;
        case (op_q)
            OP_ADD:  add_c0 = 1'b0;
            OP_SUB:  add_c0 = 1'b1;
            OP_ADDC: add_c0 = carry_q;
            OP_SUBB: add_c0 = carry_q;
            default: add_c0 = 1'b0;
        endcase
    end

    always_comb begin
        advance  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || advance;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        flag_n = add_s[WIDTH-1];
        flag_z = (add_s[WIDTH-1:0] == '0);
        flag_c = add_s[WIDTH];
        flag_v = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_s[WIDTH-1] != add_a[WIDTH-1]);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        flags_d    = flags_q;
        carry_d    = carry_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            op_d       = in_op;
            a_d        = in_a;
            b_d        = in_b;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (advance) begin
            s2_valid_d = 1'b1;
            res_d      = add_s[WIDTH-1:0];
            flags_d    = {flag_n, flag_z, flag_c, flag_v};
            carry_d    = add_s[WIDTH];
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
            carry_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            carry_q    <= carry_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_res    = res_q;
    assign out_flags  = flags_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_addsub_issue_stage.sv
// Directed-vector and stress bench for addsub_issue_stage at WIDTH=8; the adder is modelled as a plain sum.
module tb_addsub_issue_stage;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a, in_b;
    logic [W-1:0] add_a, add_b;
    logic         add_c0;
    logic [W:0]   add_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [3:0]   out_flags;
    logic         carry_flag;

    int errors = 0;
    int checks = 0;

    addsub_issue_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_flags(out_flags), .carry_flag(carry_flag)
    );

    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_b;
        logic       exp_c0;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op into an empty pipeline with out_ready=1 and check both stages.
    task automatic issue_one(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_add_a"}, 32'(add_a), 32'(v.a));
        chk({tag, "_add_b"}, 32'(add_b), 32'(v.exp_b));
        chk({tag, "_add_c0"}, 32'(add_c0), 32'(v.exp_c0));
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(out_res), 32'(v.exp_res));
        chk({tag, "_flags"}, 32'(out_flags), 32'(v.exp_flags));
        chk({tag, "_carry"}, 32'(carry_flag), 32'(v.exp_carry));
        $display("txn %s op=%0d a=%02h b=%02h -> res=%02h flags=%04b carry=%0d",
                 tag, v.op, v.a, v.b, out_res, out_flags, carry_flag);
    endtask

    // Two ops back to back, out_ready=1; the second depends on the first's carry.
    task automatic chain(input string tag,
                         input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic [1:0] op2, input logic [7:0] a2, input logic [7:0] b2,
                         input logic [7:0] r1, input logic c1,
                         input logic c0_2, input logic [7:0] r2, input logic carry2);
        @(negedge clk);
        in_valid = 1'b1; in_op = op1; in_a = a1; in_b = b1;
        @(posedge clk);
        @(negedge clk);
        in_op = op2; in_a = a2; in_b = b2;
        #1 chk({tag, "_ready2"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_c0_2"}, 32'(add_c0), 32'(c0_2));
        chk({tag, "_res1"}, 32'(out_res), 32'(r1));
        chk({tag, "_c1"}, 32'(out_flags[1]), 32'(c1));
        @(negedge clk);
        #1;
        chk({tag, "_valid2"}, 32'(out_valid), 32'd1);
        chk({tag, "_res2"}, 32'(out_res), 32'(r2));
        chk({tag, "_carry2"}, 32'(carry_flag), 32'(carry2));
        $display("txn %s -> first=%02h second=%02h carry=%0d", tag, r1, out_res, carry_flag);
    endtask

    function automatic logic [12:0] model(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        logic [7:0] bb;
        logic       cin;
        logic [8:0] s;
        logic       v;
        bb  = op[1] ? ~b : b;
        cin = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : c;
        s   = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
        v   = (a[7] == bb[7]) && (s[7] != a[7]);
        return {s[8], s[7:0], s[7], (s[7:0] == 8'd0), s[8], v};
    endfunction

    logic [7:0]  bp_vals [3];
    logic [7:0]  bp_exp  [3];
    logic [11:0] sb_q [$];

    initial begin
        int idx;
        int got;
        logic acc;
        logic accepted;
        int ops_in, ops_out, cyc;
        logic mcarry;
        logic [12:0] m;
        logic [11:0] front;

        vecs[0]  = '{2'b00, 8'h7F, 8'h01, 8'h01, 1'b0, 8'h80, 4'b1001, 1'b0};
        vecs[1]  = '{2'b10, 8'h05, 8'h05, 8'hFA, 1'b1, 8'h00, 4'b0110, 1'b1};
        vecs[2]  = '{2'b10, 8'h00, 8'h01, 8'hFE, 1'b1, 8'hFF, 4'b1000, 1'b0};
        vecs[3]  = '{2'b00, 8'hFF, 8'h01, 8'h01, 1'b0, 8'h00, 4'b0110, 1'b1};
        vecs[4]  = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000, 1'b0};
        vecs[5]  = '{2'b11, 8'h00, 8'h00, 8'hFF, 1'b0, 8'hFF, 4'b1000, 1'b0};
        vecs[6]  = '{2'b00, 8'h80, 8'h80, 8'h80, 1'b0, 8'h00, 4'b0111, 1'b1};
        vecs[7]  = '{2'b01, 8'h10, 8'h10, 8'h10, 1'b1, 8'h21, 4'b0000, 1'b0};
        vecs[8]  = '{2'b10, 8'h80, 8'h01, 8'hFE, 1'b1, 8'h7F, 4'b0011, 1'b1};
        vecs[9]  = '{2'b11, 8'h05, 8'h03, 8'hFC, 1'b1, 8'h02, 4'b0010, 1'b1};
        vecs[10] = '{2'b00, 8'h12, 8'h34, 8'h34, 1'b0, 8'h46, 4'b0000, 1'b0};
        bp_vals[0] = 8'h01; bp_vals[1] = 8'h02; bp_vals[2] = 8'h03;
        bp_exp[0]  = 8'h02; bp_exp[1]  = 8'h04; bp_exp[2]  = 8'h06;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        chk("rst_res", 32'(out_res), 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_c0}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            issue_one(vecs[i], $sformatf("v%0d", i));

        chain("chain_add", 2'b00, 8'hFF, 8'h01, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        chain("chain_sub", 2'b10, 8'h00, 8'h01, 2'b11, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0);
        chain("chain_subc", 2'b10, 8'h05, 8'h03, 2'b11, 8'h00, 8'h00, 8'h02, 1'b1, 1'b1, 8'h00, 1'b1);

        // Backpressure: two ops fill the stages, the third must wait.
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = 1'b1; in_op = 2'b00; in_a = bp_vals[idx]; in_b = bp_vals[idx];
            #1;
            if (c >= 2) chk($sformatf("bp_hold_%0d", c), 32'({out_valid, out_res}), 32'({1'b1, 8'h02}));
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        #1;
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_held_res", 32'(out_res), 32'h02);
        got = 0;
        accepted = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) out_ready = 1'b1;
            else if (accepted) in_valid = 1'b0;
            #1;
            if (out_valid) begin
                if (got < 3) chk($sformatf("bp_out_%0d", got), 32'(out_res), 32'(bp_exp[got]));
                else chk("bp_extra_output", 32'(out_res), 32'hFFFF);
                got++;
            end
            if (in_valid && in_ready) accepted = 1'b1;
            if (c == 2) chk("bp_one_per_cycle", 32'(got), 32'd3);
        end
        chk("bp_total_out", 32'(got), 32'd3);
        $display("txn backpressure -> accepted_before_release=%0d outputs=%0d", idx, got);

        // Reset with both stages full and carry set.
        issue_one('{2'b00, 8'hFF, 8'h01, 8'h01, 1'b0, 8'h00, 4'b0110, 1'b1}, "pre_rst");
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_a = 8'hFF; in_b = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_a = 8'h80; in_b = 8'h80;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("prerst_full", 32'({out_valid, in_ready, carry_flag}), 32'b101);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_carry", 32'(carry_flag), 32'd0);
        chk("rst_mid_res", 32'(out_res), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk($sformatf("post_rst_idle_%0d", c), 32'(out_valid), 32'd0);
        end
        issue_one('{2'b01, 8'h10, 8'h10, 8'h10, 1'b0, 8'h20, 4'b0000, 1'b0}, "post_rst_addc");

        // Random stress against the reference model.
        ops_in = 0; ops_out = 0; cyc = 0; acc = 1'b0;
        mcarry = carry_flag;
        @(negedge clk);
        while (ops_out < 10000 && cyc < 60000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (acc) in_valid = 1'b0;
            if (!in_valid && ops_in < 10000 && $urandom_range(0, 99) < 70) begin
                in_valid = 1'b1;
                in_op = 2'($urandom_range(0, 3));
                in_a = 8'($urandom_range(0, 255));
                in_b = 8'($urandom_range(0, 255));
            end
            out_ready = ($urandom_range(0, 99) < 70);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("rand_unexpected_out", 32'(out_res), 32'hFFFF);
                end else begin
                    front = sb_q.pop_front();
                    chk($sformatf("rand_%0d", ops_out), 32'({out_res, out_flags}), 32'(front));
                end
                ops_out++;
            end
            if (acc) begin
                m = model(in_op, in_a, in_b, mcarry);
                mcarry = m[12];
                sb_q.push_back(m[11:0]);
                ops_in++;
            end
        end
        in_valid = 1'b0;
        chk("rand_within_budget", 32'(cyc < 60000), 32'd1);
        chk("rand_count_out", 32'(ops_out), 32'd10000);
        chk("rand_in_eq_out", 32'(ops_in), 32'(ops_out));
        chk("rand_final_carry", 32'(carry_flag), 32'(mcarry));
        $display("txn random -> in=%0d out=%0d cycles=%0d", ops_in, ops_out, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_issue_stage.md
Name: addsub_issue_stage

Overview:
- Two-stage valid/ready pipeline that wraps the combinational Brent-Kung adder instance on both sides.
- Upstream, it registers op and operands, forms the adder's A/B/c0 (operand inversion for subtract, carry-in from the carry flag).
- Downstream, it captures the adder sum and carry-out, derives N/Z/C/V flags and holds the result under output backpressure.
- It keeps an architectural carry flag, so ADDC/SUBB chains build multi-word arithmetic.

Parameters:
- WIDTH, 32, operand width; must equal the adder's INPUTSIZE.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- in_op  in  2  operation: 00 ADD, 01 ADDC, 10 SUB, 11 SUBB.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- add_a  out  WIDTH  A to the adder.
- add_b  out  WIDTH  B to the adder, possibly inverted.
- add_c0  out  1  carry-in to the adder.
- add_s  in  WIDTH+1  adder sum; bit WIDTH is carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  WIDTH  result, add_s[WIDTH-1:0].
- out_flags  out  4  {N,Z,C,V}.
- carry_flag  out  1  current architectural carry.

Behaviour:
- Reset, asynchronous on rst_n low:
  - s1_valid=0, s2_valid=0, out_valid=0, carry_flag=0.
  - out_res=0, out_flags=0, add_a=0, add_b=0, add_c0=0.
  - A reset mid-operation discards all in-flight ops; nothing is emitted after release.
- Stage S1 (operand register):
  - Loads in_op/in_a/in_b on in_valid && in_ready; sets s1_valid.
  - Its registered outputs drive add_a, add_b and add_c0 directly. The adder output is therefore valid the same cycle, with no combinational path from in_* to add_*.
- Operand forming:
  - add_a = A.
  - add_b = B for ADD/ADDC; ~B for SUB/SUBB.
  - add_c0: 0 for ADD; 1 for SUB; carry_flag for ADDC/SUBB.
- carry_flag is sampled combinationally in the cycle the op sits in S1 before advancing, so back-to-back chained ops see the predecessor's carry.
- Stage S2 (result register):
  - Advance condition: s1_valid && (!s2_valid || out_ready).
  - On advance, S2 captures out_res = add_s[WIDTH-1:0] and computes:
    - N = add_s[WIDTH-1]
    - Z = (add_s[WIDTH-1:0]==0)
    - C = add_s[WIDTH]
    - V = (A[W-1]==add_b[W-1]) && (add_s[W-1]!=A[W-1])
  - carry_flag <= add_s[WIDTH] on the same edge. For SUB, C=1 means no borrow.
- Handshake:
  - in_ready = !s1_valid || advance. Combinational from out_ready; no path from in_valid.
  - out_valid = s2_valid.
  - s2_valid clears on out_ready when no advance occurs.
  - Simultaneous accept on both ends keeps full throughput: one op per cycle.
  - Output data is stable while out_valid && !out_ready.
- Latency: accept at edge t; out_valid high after edge t+1 (2 edges).
- Full: s1 and s2 both valid and out_ready=0 forces in_ready=0. Neither stage may be overwritten.
- Empty: out_valid=0. The add_* outputs hold the last S1 contents; don't-care to the adder.
- Ordering: strict FIFO. No op reordering or dropping.
- Width: all arithmetic is modulo 2^WIDTH. The carry-out comes only from add_s[WIDTH]. The block performs no sign correction of its own.

Test Plan:
- WIDTH=8 for all scenarios.
- ADD 0x7F+0x01, out_ready=1 -> add_b=0x01, add_c0=0; two edges later out_res=0x80, flags N=1 Z=0 C=0 V=1.
- SUB 0x05-0x05 -> add_b=0xFA, add_c0=1; out_res=0x00, N=0 Z=1 C=1 V=0. Then SUB 0x00-0x01 -> out_res=0xFF, N=1 C=0 V=0.
- Chained, back-to-back: ADD 0xFF+0x01 then ADDC 0x00+0x00 -> first out_res=0x00 C=1; second add_c0=1, out_res=0x01 C=0, carry_flag=0. Repeat with SUB 0x00-0x01 then SUBB 0x00-0x00 -> second result 0xFF.
- Backpressure: out_ready=0 for 5 cycles, in_valid=1 with ops 0x01+0x01, 0x02+0x02, 0x03+0x03 -> two accepted, then in_ready=0. out_res=0x02 is held stable. Release out_ready -> 0x02, 0x04, 0x06 in order, one per cycle, no loss.
- Reset mid-operation: rst_n low with s1/s2 full and carry_flag=1 -> out_valid=0 and carry_flag=0 immediately, before the next clk edge. After release, the next ADDC 0x10+0x10 -> 0x20.
- Random stress: 10k ops with random in_valid/out_ready against a reference model, including carry_flag chaining -> all results and flags match, count in == count out.
